// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle control sequencer for the 16-bit RISC core
module cpu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_in,
  input  logic [15:0]      ins_in,
  input  logic             zero_in,
  input  logic             neg_in,
  input  logic             mem_ack_in,
  output logic [1:0]       ps_out,
  output logic             ir_load_out,
  output logic             rf_we_out,
  output logic             mem_req_out,
  output logic             mem_we_out,
  output logic             addr_sel_out,
  output logic             halted_out,
  output logic             bus_err_out,
  output logic             illegal_out,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] instret_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BRZ   = 4'h4;
  localparam logic [3:0] OP_BRN   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Timeout counter only needs to cover the 1..255 parameter range.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [7:0]       r_tmo;
  logic [CNT_W-1:0] r_instret;

  logic [3:0] w_op;
  logic       w_defined;
  logic       w_retire;
  logic       w_tmo_hit;
  logic       w_unused_ins;

  assign w_op         = ins_in[15:12];
  assign w_unused_ins = ^ins_in[11:0];
  assign w_defined    = (w_op <= OP_JMP) || (w_op == OP_HALT);
  assign w_tmo_hit    = (r_tmo == TMO_LAST) && !mem_ack_in;

  // Control outputs decoded from the current state and the live inputs.
  always_comb begin
    ps_out       = 2'b00;
    ir_load_out  = 1'b0;
    rf_we_out    = 1'b0;
    mem_req_out  = 1'b0;
    mem_we_out   = 1'b0;
    addr_sel_out = 1'b0;
    halted_out   = 1'b0;
    bus_err_out  = 1'b0;
    illegal_out  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req_out = 1'b1;
        ir_load_out = mem_ack_in;
      end
      S_DECODE: illegal_out = !w_defined;
      S_EXEC: begin
        case (w_op)
          OP_ALU: begin
            rf_we_out = 1'b1;
            ps_out    = 2'b01;
          end
          OP_LOAD, OP_STORE, OP_HALT: ps_out = 2'b00;
          OP_BRZ: ps_out = zero_in ? 2'b10 : 2'b01;
          OP_BRN: ps_out = neg_in ? 2'b10 : 2'b01;
          OP_JMP: ps_out = 2'b11;
          default: ps_out = 2'b01;  // NOP and undefined opcodes just advance
        endcase
      end
      S_MEM: begin
        mem_req_out  = 1'b1;
        addr_sel_out = 1'b1;
        mem_we_out   = (w_op == OP_STORE);
        if (mem_ack_in) begin
          ps_out    = 2'b01;
          rf_we_out = (w_op == OP_LOAD);
        end
      end
      S_HALT: halted_out = 1'b1;
      S_ERROR: begin
        halted_out  = 1'b1;
        bus_err_out = 1'b1;
      end
      default: ;
    endcase
  end

  // An instruction retires when the PC moves or when HALT is executed.
  assign w_retire = (ps_out != 2'b00) || ((r_state == S_EXEC) && (w_op == OP_HALT));

  assign state_out   = r_state;
  assign instret_out = r_instret;

  // Sequencer state, bus timeout counter and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tmo     <= 8'd0;
      r_instret <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + 1'b1;

      // Counter runs only while a bus request is waiting; any ack or any
      // other state leaves it at zero so every FETCH/MEM entry starts fresh.
      if (((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ack_in)
        r_tmo <= r_tmo + 8'd1;
      else
        r_tmo <= 8'd0;

      case (r_state)
        S_IDLE:   if (run_in) r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack_in)     r_state <= S_DECODE;
          else if (w_tmo_hit) r_state <= S_ERROR;
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_op == OP_HALT)                           r_state <= S_HALT;
          else if ((w_op == OP_LOAD) || (w_op == OP_STORE)) r_state <= S_MEM;
          else                                           r_state <= run_in ? S_FETCH : S_IDLE;
        end
        S_MEM: begin
          if (mem_ack_in)     r_state <= run_in ? S_FETCH : S_IDLE;
          else if (w_tmo_hit) r_state <= S_ERROR;
        end
        S_HALT:   r_state <= S_HALT;
        S_ERROR:  r_state <= S_ERROR;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - scoreboard bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_HALT = 3'd5, ST_ERR = 3'd6;
  localparam logic [7:0] IRL = 8'h80, RFW = 8'h40, REQ = 8'h20, WE = 8'h10;
  localparam logic [7:0] ASEL = 8'h08, HLT = 8'h04, BERR = 8'h02, ILL = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_in = 1'b0;
  logic [15:0] ins_in = 16'h0000;
  logic        zero_in = 1'b0;
  logic        neg_in = 1'b0;
  logic        mem_ack_in = 1'b0;
  logic [1:0]  ps_out;
  logic        ir_load_out, rf_we_out, mem_req_out, mem_we_out, addr_sel_out;
  logic        halted_out, bus_err_out, illegal_out;
  logic [2:0]  state_out;
  logic [15:0] instret_out;

  int n_checks = 0;
  int n_fail   = 0;

  string       q_tag[$];
  logic [12:0] q_exp[$];

  cpu_seq_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run_in(run_in), .ins_in(ins_in),
    .zero_in(zero_in), .neg_in(neg_in), .mem_ack_in(mem_ack_in),
    .ps_out(ps_out), .ir_load_out(ir_load_out), .rf_we_out(rf_we_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .addr_sel_out(addr_sel_out),
    .halted_out(halted_out), .bus_err_out(bus_err_out), .illegal_out(illegal_out),
    .state_out(state_out), .instret_out(instret_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] observed();
    return {state_out, ps_out, ir_load_out, rf_we_out, mem_req_out, mem_we_out,
            addr_sel_out, halted_out, bus_err_out, illegal_out};
  endfunction

  // Scoreboard: one expected output vector per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q_exp.size() > 0) check_eq(q_tag.pop_front(), 32'(observed()), 32'(q_exp.pop_front()));
  end

  task automatic cyc(input string tag, input logic run, input logic [15:0] ins,
                     input logic z, input logic n, input logic ack,
                     input logic [2:0] st, input logic [1:0] ps, input logic [7:0] ctl);
    run_in = run; ins_in = ins; zero_in = z; neg_in = n; mem_ack_in = ack;
    q_tag.push_back(tag);
    q_exp.push_back({st, ps, ctl});
    @(posedge clk); #1;
  endtask

  task automatic fetch_dec(input string tag, input logic [15:0] ins, input logic [7:0] dec_ctl);
    cyc({tag, "_fetch"}, 1'b1, ins, 1'b0, 1'b0, 1'b1, ST_FETCH, 2'b00, REQ | IRL);
    cyc({tag, "_dec"},   1'b1, ins, 1'b0, 1'b0, 1'b0, ST_DEC,   2'b00, dec_ctl);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc("in_rst0", 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, ST_IDLE, 2'b00, 8'h00);
    cyc("in_rst1", 1'b1, 16'h3000, 1'b1, 1'b1, 1'b1, ST_IDLE, 2'b00, 8'h00);
    rst = 1'b0;
    cyc("post_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, ST_IDLE, 2'b00, 8'h00);
    check_eq("instret_rst", 32'(instret_out), 32'd0);
    cyc("idle_run", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, ST_IDLE, 2'b00, 8'h00);

    // ALU with two wait states on the fetch
    cyc("alu_fw0", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, ST_FETCH, 2'b00, REQ);
    cyc("alu_fw1", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, ST_FETCH, 2'b00, REQ);
    fetch_dec("alu", 16'h1234, 8'h00);
    cyc("alu_exec", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, ST_EXEC, 2'b01, RFW);
    check_eq("instret_alu", 32'(instret_out), 32'd1);

    // Branches and jump
    fetch_dec("brz1", 16'h4000, 8'h00);
    cyc("brz1_exec", 1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, ST_EXEC, 2'b10, 8'h00);
    fetch_dec("brz0", 16'h4000, 8'h00);
    cyc("brz0_exec", 1'b1, 16'h4000, 1'b0, 1'b1, 1'b0, ST_EXEC, 2'b01, 8'h00);
    fetch_dec("brn1", 16'h5000, 8'h00);
    cyc("brn1_exec", 1'b1, 16'h5000, 1'b0, 1'b1, 1'b0, ST_EXEC, 2'b10, 8'h00);
    fetch_dec("jmp", 16'h6000, 8'h00);
    cyc("jmp_exec", 1'b1, 16'h6000, 1'b0, 1'b0, 1'b0, ST_EXEC, 2'b11, 8'h00);
    check_eq("instret_br", 32'(instret_out), 32'd5);

    // LOAD with three wait states
    fetch_dec("ld", 16'h2000, 8'h00);
    cyc("ld_exec", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b1, ST_EXEC, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++)
      cyc("ld_wait", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, ST_MEM, 2'b00, REQ | ASEL);
    cyc("ld_ack", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b1, ST_MEM, 2'b01, REQ | ASEL | RFW);
    check_eq("instret_ld", 32'(instret_out), 32'd6);

    // STORE with one wait state
    fetch_dec("st", 16'h3000, 8'h00);
    cyc("st_exec", 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, ST_EXEC, 2'b00, 8'h00);
    cyc("st_wait", 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, ST_MEM, 2'b00, REQ | ASEL | WE);
    cyc("st_ack", 1'b1, 16'h3000, 1'b0, 1'b0, 1'b1, ST_MEM, 2'b01, REQ | ASEL | WE);

    // Undefined opcode behaves as NOP with an illegal pulse
    fetch_dec("ill", 16'hA000, ILL);
    cyc("ill_exec", 1'b1, 16'hA000, 1'b0, 1'b0, 1'b0, ST_EXEC, 2'b01, 8'h00);
    check_eq("instret_ill", 32'(instret_out), 32'd8);

    // Ack on the last allowed fetch cycle wins over the timeout
    for (int i = 0; i < 14; i++)
      cyc("lim_wait", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, ST_FETCH, 2'b00, REQ);
    cyc("lim_ack", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, ST_FETCH, 2'b00, REQ | IRL);
    cyc("lim_dec", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, ST_DEC, 2'b00, 8'h00);
    cyc("nop_exec", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, ST_EXEC, 2'b01, 8'h00);

    // run_in dropped during MEM: instruction finishes, then IDLE
    fetch_dec("ldr", 16'h2000, 8'h00);
    cyc("ldr_exec", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, ST_EXEC, 2'b00, 8'h00);
    cyc("ldr_wait", 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0, ST_MEM, 2'b00, REQ | ASEL);
    cyc("ldr_ack", 1'b0, 16'h2000, 1'b0, 1'b0, 1'b1, ST_MEM, 2'b01, REQ | ASEL | RFW);
    cyc("ldr_idle", 1'b0, 16'h2000, 1'b0, 1'b0, 1'b1, ST_IDLE, 2'b00, 8'h00);
    check_eq("instret_ldr", 32'(instret_out), 32'd10);
    cyc("idle_run2", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, ST_IDLE, 2'b00, 8'h00);

    // Unacknowledged fetch times out into ERROR after 15 cycles
    for (int i = 0; i < 15; i++)
      cyc("tmo_wait", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, ST_FETCH, 2'b00, REQ);
    cyc("err0", 1'b1, 16'h1000, 1'b0, 1'b0, 1'b1, ST_ERR, 2'b00, HLT | BERR);
    cyc("err1", 1'b1, 16'h1000, 1'b0, 1'b0, 1'b1, ST_ERR, 2'b00, HLT | BERR);
    check_eq("instret_err", 32'(instret_out), 32'd10);

    // Asynchronous reset out of ERROR clears state and flags at once
    rst = 1'b1;
    #1;
    check_eq("rst_async", 32'(observed()), 32'd0);
    check_eq("rst_instret", 32'(instret_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("rst_idle", 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, ST_IDLE, 2'b00, 8'h00);

    // HALT retires once and then ignores run_in and acks
    fetch_dec("hlt", 16'hF000, 8'h00);
    cyc("hlt_exec", 1'b1, 16'hF000, 1'b1, 1'b1, 1'b0, ST_EXEC, 2'b00, 8'h00);
    cyc("hlt0", 1'b0, 16'hF000, 1'b0, 1'b0, 1'b1, ST_HALT, 2'b00, HLT);
    cyc("hlt1", 1'b1, 16'h1000, 1'b0, 1'b0, 1'b1, ST_HALT, 2'b00, HLT);
    check_eq("instret_hlt", 32'(instret_out), 32'd1);

    @(negedge clk); #1;
    check_eq("sb_drained", 32'(q_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
